// File: rtl/redmule_tile_sequencer_if.sv
// Load/store request bus between the RedMulE tile sequencer (master) and the
// datapath engine (slave).
interface redmule_tile_sequencer_if #(
   parameter int unsigned CntWidth = 16
) ();
   logic                ld_valid_o;
   logic                ld_ready_i;
   logic [CntWidth-1:0] m_idx_o;
   logic [CntWidth-1:0] n_idx_o;
   logic [CntWidth-1:0] k_idx_o;
   logic                ld_last_k_o;
   logic                acc_done_i;
   logic                st_valid_o;
   logic                st_ready_i;

   modport master (
      output ld_valid_o, m_idx_o, n_idx_o, k_idx_o, ld_last_k_o, st_valid_o,
      input  ld_ready_i, acc_done_i, st_ready_i
   );

   modport slave (
      input  ld_valid_o, m_idx_o, n_idx_o, k_idx_o, ld_last_k_o, st_valid_o,
      output ld_ready_i, acc_done_i, st_ready_i
   );
endinterface

// File: rtl/redmule_tile_sequencer.sv
// Walks an M x N x K tile space (m outer, n middle, k inner), issuing load and
// store requests. Define REDMULE_SEQ_PERF_EN to build the busy/stall counters.
module redmule_tile_sequencer #(
   parameter int unsigned CntWidth  = 16,
   parameter int unsigned PerfWidth = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     start_i,
   input  logic [CntWidth-1:0]      m_tiles_i,
   input  logic [CntWidth-1:0]      n_tiles_i,
   input  logic [CntWidth-1:0]      k_tiles_i,
   redmule_tile_sequencer_if.master seq_if,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic [PerfWidth-1:0]     cycle_cnt_o,
   output logic [PerfWidth-1:0]     stall_cnt_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      WAIT_ACC = 3'd2,
      STORE    = 3'd3,
      FINISH   = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [CntWidth-1:0] m_tot_q, m_tot_d, n_tot_q, n_tot_d, k_tot_q, k_tot_d;
   logic [CntWidth-1:0] m_idx_q, m_idx_d, n_idx_q, n_idx_d, k_idx_q, k_idx_d;
   logic                ld_valid_q, ld_valid_d, st_valid_q, st_valid_d;
   logic                ld_last_q, ld_last_d;
   logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                ld_hs, st_hs;

   // Next-state and registered-output computation for the tile walk.
   always_comb begin
      state_d    = state_q;
      m_tot_d    = m_tot_q;
      n_tot_d    = n_tot_q;
      k_tot_d    = k_tot_q;
      m_idx_d    = m_idx_q;
      n_idx_d    = n_idx_q;
      k_idx_d    = k_idx_q;
      ld_valid_d = ld_valid_q;
      st_valid_d = st_valid_q;
      ld_last_d  = ld_last_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      ld_hs      = ld_valid_q && seq_if.ld_ready_i;
      st_hs      = st_valid_q && seq_if.st_ready_i;

      if (clear_i) begin
         state_d    = IDLE;
         m_tot_d    = '0;
         n_tot_d    = '0;
         k_tot_d    = '0;
         m_idx_d    = '0;
         n_idx_d    = '0;
         k_idx_d    = '0;
         ld_valid_d = 1'b0;
         st_valid_d = 1'b0;
         ld_last_d  = 1'b0;
         busy_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  busy_d = 1'b1;
                  if ((m_tiles_i == '0) || (n_tiles_i == '0) || (k_tiles_i == '0)) begin
                     state_d = FINISH;
                     done_d  = 1'b1;
                     err_d   = 1'b1;
                  end else begin
                     state_d    = LOAD;
                     m_tot_d    = m_tiles_i;
                     n_tot_d    = n_tiles_i;
                     k_tot_d    = k_tiles_i;
                     m_idx_d    = '0;
                     n_idx_d    = '0;
                     k_idx_d    = '0;
                     ld_valid_d = 1'b1;
                     ld_last_d  = (k_tiles_i == CntWidth'(1));
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            LOAD: begin
               if (ld_hs) begin
                  if (k_idx_q == k_tot_q - CntWidth'(1)) begin
                     k_idx_d    = '0;
                     state_d    = WAIT_ACC;
                     ld_valid_d = 1'b0;
                     ld_last_d  = 1'b0;
                  end else begin
                     k_idx_d   = k_idx_q + CntWidth'(1);
                     ld_last_d = (k_idx_q + CntWidth'(1) == k_tot_q - CntWidth'(1));
                  end
               end else begin
                  state_d = LOAD;
               end
            end
            WAIT_ACC: begin
               if (seq_if.acc_done_i) begin
                  state_d    = STORE;
                  st_valid_d = 1'b1;
               end else begin
                  state_d = WAIT_ACC;
               end
            end
            STORE: begin
               if (st_hs) begin
                  st_valid_d = 1'b0;
                  if (n_idx_q < n_tot_q - CntWidth'(1)) begin
                     n_idx_d    = n_idx_q + CntWidth'(1);
                     state_d    = LOAD;
                     ld_valid_d = 1'b1;
                     ld_last_d  = (k_tot_q == CntWidth'(1));
                  end else begin
                     n_idx_d = '0;
                     if (m_idx_q < m_tot_q - CntWidth'(1)) begin
                        m_idx_d    = m_idx_q + CntWidth'(1);
                        state_d    = LOAD;
                        ld_valid_d = 1'b1;
                        ld_last_d  = (k_tot_q == CntWidth'(1));
                     end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                     end
                  end
               end else begin
                  state_d = STORE;
               end
            end
            FINISH: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               state_d    = IDLE;
               ld_valid_d = 1'b0;
               st_valid_d = 1'b0;
               ld_last_d  = 1'b0;
               busy_d     = 1'b0;
            end
         endcase
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         m_tot_q    <= '0;
         n_tot_q    <= '0;
         k_tot_q    <= '0;
         m_idx_q    <= '0;
         n_idx_q    <= '0;
         k_idx_q    <= '0;
         ld_valid_q <= 1'b0;
         st_valid_q <= 1'b0;
         ld_last_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_tot_q    <= m_tot_d;
         n_tot_q    <= n_tot_d;
         k_tot_q    <= k_tot_d;
         m_idx_q    <= m_idx_d;
         n_idx_q    <= n_idx_d;
         k_idx_q    <= k_idx_d;
         ld_valid_q <= ld_valid_d;
         st_valid_q <= st_valid_d;
         ld_last_q  <= ld_last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign seq_if.ld_valid_o  = ld_valid_q;
   assign seq_if.st_valid_o  = st_valid_q;
   assign seq_if.m_idx_o     = m_idx_q;
   assign seq_if.n_idx_o     = n_idx_q;
   assign seq_if.k_idx_o     = k_idx_q;
   assign seq_if.ld_last_k_o = ld_last_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign err_o              = err_q;

`ifdef REDMULE_SEQ_PERF_EN
   logic [PerfWidth-1:0] cycle_cnt_q, cycle_cnt_d, stall_cnt_q, stall_cnt_d;
   logic                 start_acc, stall_now;

   // Saturating busy/stall counters, restarted by each accepted start.
   always_comb begin
      start_acc   = (state_q == IDLE) && start_i;
      stall_now   = (ld_valid_q && !seq_if.ld_ready_i) || (st_valid_q && !seq_if.st_ready_i);
      cycle_cnt_d = cycle_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (clear_i || start_acc) begin
         cycle_cnt_d = '0;
         stall_cnt_d = '0;
      end else begin
         if (busy_q && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + PerfWidth'(1);
         end else begin
            cycle_cnt_d = cycle_cnt_q;
         end
         if (stall_now && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PerfWidth'(1);
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign cycle_cnt_o = cycle_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`else
   assign cycle_cnt_o = '0;
   assign stall_cnt_o = '0;
`endif

endmodule
